config_sram_serializer: RTL and testbench
=========================================

Name: config_sram_serializer

Overview:
- Initiator side of the config SRAM data shift protocol.
- Accepts one parallel (address, data) write request over a valid/ready handshake.
- Serializes the request onto the config shift chain using shift_enable and shift_in, then pulses config_set so the chain commits an SRAM write.
- Sits between the config controller and the config_sram_data chain.

Parameters:
- ADDR_BITS, 8: width of the write address field.
- DATA_BITS, 8: width of the write data field.

Ports:
- cclk  input  1  config clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  write request is valid.
- req_ready  output  1  block can accept a request (IDLE only).
- req_addr  input  ADDR_BITS  SRAM write address.
- req_data  input  DATA_BITS  SRAM write data.
- shift_enable  output  1  chain shift strobe.
- shift_in  output  1  serial bit into the chain.
- shift_out  input  1  serial bit returned from the chain end.
- config_set  output  1  one-cycle commit strobe to the chain.
- done  output  1  one-cycle pulse, coincident with config_set.
- busy  output  1  high in SHIFT or SET.

Behaviour:
- Localparam N = ADDR_BITS + DATA_BITS.
- Shift word W = {req_data, req_addr}. Bits are sent W[N-1] first, down to W[0] last; data MSB goes first and address LSB goes last.
- Bit counter is $clog2(N+1) bits wide.
- State machine: IDLE, SHIFT, SET.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready at an edge: latch W into the shift register, clear the counter, go to SHIFT.
  - If req_valid is low, stay in IDLE.
- SHIFT:
  - Registered shift_enable = 1; shift_in = current W MSB.
  - Each cycle: W shifts left by one and the counter increments.
  - Exactly N consecutive cycles with shift_enable high, no gaps.
  - After the Nth bit, go to SET.
- SET:
  - shift_enable = 0; config_set = 1 and done = 1 for exactly one cycle.
  - Next state is IDLE.
- Latency: handshake edge at cycle 0; shift cycles 1..N; config_set at cycle N+1; req_ready high again at cycle N+2. No back-to-back overlap.
- shift_in is 0 whenever shift_enable is low.
- config_set and shift_enable are never high in the same cycle.
- req_* inputs are ignored outside IDLE; latched values cannot be disturbed by them.
- Reset values: state IDLE; shift_enable, shift_in, config_set, done, busy all 0; req_ready 1 from the first cycle after reset. Internal registers are 0.
- Reset mid-SHIFT or mid-SET:
  - Return to IDLE next cycle with all strobes low.
  - config_set is not asserted; the partially shifted chain is left as is and no write occurs.
- N = 1 is legal (one shift cycle).

Optional Feature:
- Macro: CFG_SER_READBACK_EN.
- Defined:
  - Adds outputs rb_word [N-1:0] and rb_valid.
  - On every edge with shift_enable high, shift_out is sampled into rb_word (shift left, LSB in).
  - rb_valid pulses with config_set. rb_word then holds the previous chain contents in the same bit order as W.
  - Reset clears rb_word and rb_valid.
- Undefined: the ports and capture logic are absent, and shift_out is unused.

Decomposition:
- Shared package cfg_ser_pkg holds:
  - the state enum (IDLE, SHIFT, SET);
  - a function computing counter width from N.
- One natural sub-module: piso_shift_reg, a parallel-load, serial-out register with load, shift, and an MSB output. It is reused for the readback capture in serial-in mode.

Test Plan:
1. Basic write. ADDR_BITS=8, DATA_BITS=8, req_addr=0x5A, req_data=0xC3.
   - shift_in sequence over 16 shift_enable cycles: 1100 0011 0101 1010.
   - config_set on cycle 17; req_ready high on cycle 18.
   - A connected config_sram_data model shows write_address=0x5A, write_data=0xC3 at config_set.
2. Back-to-back requests: 0x01/0xFF, then 0xFE/0x00 with req_valid held high.
   - Second accepted only on cycle 18.
   - Exactly two config_set pulses, 18 cycles apart.
   - Chain model shows both writes.
3. Inputs changed mid-shift: req_addr/req_data changed at cycle 5 of a 0x33/0x44 write.
   - Serialized stream unchanged; committed write is 0x33/0x44.
4. Reset mid-operation: rst asserted at shift cycle 7.
   - Next cycle: shift_enable=0, busy=0, req_ready=1.
   - No config_set pulse; the next request 0x10/0x20 completes normally.
5. Idle: req_valid=0 for 50 cycles.
   - shift_enable, shift_in, and config_set stay 0; req_ready stays 1.
6. Readback (CFG_SER_READBACK_EN). Chain model preloaded with {data=0xA5, addr=0x3C}; write 0x00/0x00.
   - rb_valid pulses with config_set and rb_word=0xA53C.

Source files
------------

// File: rtl/cfg_ser_pkg.sv
// Shared types and helpers for the config SRAM serializer.
package cfg_ser_pkg;

    // Serializer sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SET   = 2'd2
    } state_t;

    // Bit counter width able to hold values 0..n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load shift register with MSB-first serial output and LSB serial input.
// Load has priority over shift; with load tied low it acts as a serial-in capture register.
module piso_shift_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q,
    output logic             msb
);

    logic [WIDTH-1:0] r_q;

    // Load a parallel word or shift left by one, taking serial_in as the new LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= load_data;
        end else if (shift) begin
            r_q <= (r_q << 1) | WIDTH'(serial_in);
        end
    end

    assign q   = r_q;
    assign msb = r_q[WIDTH-1];

endmodule

// File: rtl/config_sram_serializer.sv
// Initiator side of the config SRAM shift protocol: accepts one (addr, data)
// write, shifts {data, addr} MSB-first onto the chain, then pulses config_set.
// Optional readback capture of the returned chain contents is enabled by
// defining CFG_SER_READBACK_EN.
//
// state | meaning
// IDLE  | ready for a request; strobes low
// SHIFT | shifting N bits onto the chain, one per cycle, no gaps
// SET   | one-cycle config_set / done commit strobe
module config_sram_serializer
    import cfg_ser_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
) (
    input  logic                           cclk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [ADDR_BITS-1:0]           req_addr,
    input  logic [DATA_BITS-1:0]           req_data,
    output logic                           shift_enable,
    output logic                           shift_in,
    input  logic                           shift_out,
    output logic                           config_set,
    output logic                           done,
    output logic                           busy
`ifdef CFG_SER_READBACK_EN
    ,
    output logic [ADDR_BITS+DATA_BITS-1:0] rb_word,
    output logic                           rb_valid
`endif
);

    localparam int N  = ADDR_BITS + DATA_BITS;
    localparam int CW = int'(cnt_width(N));

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    w_word;
    logic            w_load;
    logic            w_shift;
    logic            w_msb;
    logic            w_last_bit;
    logic [N-1:0]    w_sreg_q_unused;

    assign w_word     = {req_data, req_addr};
    assign w_last_bit = (r_cnt == CW'(N - 1));

    piso_shift_reg #(
        .WIDTH(N)
    ) u_tx_sreg (
        .clk       (cclk),
        .rst       (rst),
        .load      (w_load),
        .shift     (w_shift),
        .load_data (w_word),
        .serial_in (1'b0),
        .q         (w_sreg_q_unused),
        .msb       (w_msb)
    );

    // State register.
    always_ff @(posedge cclk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bit counter: cleared on accept, advances once per shifted bit.
    always_ff @(posedge cclk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_load) begin
            r_cnt <= '0;
        end else if (w_shift) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Next-state and output decode; all outputs are decodes of registered state.
    always_comb begin
        w_state_nxt  = r_state;
        req_ready    = 1'b0;
        shift_enable = 1'b0;
        shift_in     = 1'b0;
        config_set   = 1'b0;
        done         = 1'b0;
        busy         = 1'b0;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy         = 1'b1;
                shift_enable = 1'b1;
                shift_in     = w_msb;
                w_shift      = 1'b1;
                if (w_last_bit) begin
                    w_state_nxt = SET;
                end
            end
            SET: begin
                busy        = 1'b1;
                config_set  = 1'b1;
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

`ifdef CFG_SER_READBACK_EN
    logic w_rb_msb_unused;

    // The chain end returns its old contents MSB-first while we shift, so a
    // serial-in capture rebuilds them in the same bit order as the sent word.
    piso_shift_reg #(
        .WIDTH(N)
    ) u_rb_sreg (
        .clk       (cclk),
        .rst       (rst),
        .load      (1'b0),
        .shift     (shift_enable),
        .load_data ('0),
        .serial_in (shift_out),
        .q         (rb_word),
        .msb       (w_rb_msb_unused)
    );

    assign rb_valid = config_set;
`else
    logic w_unused_shift_out;
    assign w_unused_shift_out = shift_out;
`endif

endmodule

// File: tb/tb_config_sram_serializer.sv
// Self-checking bench for config_sram_serializer with a config_sram_data chain
// model; readback checks are included when CFG_SER_READBACK_EN is defined.
module tb_config_sram_serializer;

    localparam int AB = 8;
    localparam int DB = 8;
    localparam int N  = AB + DB;

    logic          cclk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AB-1:0] req_addr = '0;
    logic [DB-1:0] req_data = '0;
    logic          shift_enable;
    logic          shift_in;
    logic          shift_out;
    logic          config_set;
    logic          done;
    logic          busy;
`ifdef CFG_SER_READBACK_EN
    logic [N-1:0]  rb_word;
    logic          rb_valid;
`endif

    always #5 cclk = ~cclk;

    config_sram_serializer #(
        .ADDR_BITS(AB),
        .DATA_BITS(DB)
    ) dut (
        .cclk         (cclk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .shift_enable (shift_enable),
        .shift_in     (shift_in),
        .shift_out    (shift_out),
        .config_set   (config_set),
        .done         (done),
        .busy         (busy)
`ifdef CFG_SER_READBACK_EN
        ,
        .rb_word      (rb_word),
        .rb_valid     (rb_valid)
`endif
    );

    // Chain model: shifts shift_in in at the LSB end, the far end feeds shift_out.
    logic [N-1:0] chain = '0;
    logic         preload_req = 1'b0;
    logic [N-1:0] preload_val = '0;

    always @(posedge cclk) begin
        if (preload_req) chain <= preload_val;
        else if (shift_enable) chain <= {chain[N-2:0], shift_in};
    end

    assign shift_out = chain[N-1];

    int           checks = 0;
    int           errors = 0;
    int           cs_count = 0;
    int           cs_before;
    int           cs_cyc[$];
    bit           bitq[$];
    logic [N-1:0] wq[$];
    logic [N-1:0] rbq[$];
    logic [N-1:0] last_rb = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected serial stream (MSB first) and expected committed word.
    task automatic push_word(input logic [AB-1:0] a, input logic [DB-1:0] d);
        logic [N-1:0] w;
        w = {d, a};
        for (int i = N - 1; i >= 0; i--) bitq.push_back(w[i]);
        wq.push_back(w);
    endtask

    task automatic monitor_cycle();
        bit           b;
        logic [N-1:0] e;
        if (!shift_enable) chk("shift_in_low", 32'(shift_in), 32'(0));
        chk("se_cs_exclusive", 32'(shift_enable & config_set), 32'(0));
        chk("done_eq_cs", 32'(done), 32'(config_set));
        if (shift_enable) begin
            chk("bitq_avail", 32'(bitq.size() != 0), 32'(1));
            if (bitq.size() != 0) begin
                b = bitq.pop_front();
                chk("shift_in", 32'(shift_in), 32'(b));
            end
        end
        if (config_set) begin
            cs_count++;
            chk("wq_avail", 32'(wq.size() != 0), 32'(1));
            if (wq.size() != 0) begin
                e = wq.pop_front();
                chk("wr_addr", 32'(chain[AB-1:0]), 32'(e[AB-1:0]));
                chk("wr_data", 32'(chain[N-1:AB]), 32'(e[N-1:AB]));
            end
        end
`ifdef CFG_SER_READBACK_EN
        chk("rb_valid", 32'(rb_valid), 32'(config_set));
        if (rb_valid) begin
            chk("rbq_avail", 32'(rbq.size() != 0), 32'(1));
            if (rbq.size() != 0) begin
                e = rbq.pop_front();
                last_rb = rb_word;
                chk("rb_word", 32'(rb_word), 32'(e));
            end
        end
`endif
    endtask

    // One write with per-cycle latency checks; glitch>0 scrambles req_* at that shift cycle.
    task automatic do_write(input logic [AB-1:0] a, input logic [DB-1:0] d, input int glitch);
        @(negedge cclk);
        chk("ready_pre", 32'(req_ready), 32'(1));
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        push_word(a, d);
        rbq.push_back(chain);
        @(posedge cclk);
        #1;
        req_valid = 1'b0;
        req_addr  = ~a;
        req_data  = ~d;
        for (int k = 1; k <= N + 2; k++) begin
            @(negedge cclk);
            chk("lat_shift_enable", 32'(shift_enable), 32'(k <= N));
            chk("lat_config_set", 32'(config_set), 32'(k == N + 1));
            chk("lat_req_ready", 32'(req_ready), 32'(k == N + 2));
            chk("lat_busy", 32'(busy), 32'(k <= N + 1));
            if (k == glitch) begin
                req_addr = AB'($urandom);
                req_data = DB'($urandom);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            forever begin
                @(negedge cclk);
                monitor_cycle();
            end
        join_none

        // Reset values
        rst = 1'b1;
        repeat (3) @(posedge cclk);
        @(negedge cclk);
        chk("rst_req_ready", 32'(req_ready), 32'(1));
        chk("rst_shift_enable", 32'(shift_enable), 32'(0));
        chk("rst_shift_in", 32'(shift_in), 32'(0));
        chk("rst_config_set", 32'(config_set), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
`ifdef CFG_SER_READBACK_EN
        chk("rst_rb_word", 32'(rb_word), 32'(0));
        chk("rst_rb_valid", 32'(rb_valid), 32'(0));
`endif
        rst = 1'b0;

        // 1: basic write, stream 1100_0011_0101_1010
        do_write(8'h5A, 8'hC3, 0);

        // 2: back-to-back with req_valid held
        @(negedge cclk);
        req_valid = 1'b1;
        req_addr  = 8'h01;
        req_data  = 8'hFF;
        push_word(8'h01, 8'hFF);
        push_word(8'hFE, 8'h00);
        rbq.push_back(chain);
        rbq.push_back({8'hFF, 8'h01});
        @(posedge cclk);
        #1;
        req_addr = 8'hFE;
        req_data = 8'h00;
        cs_cyc.delete();
        for (int k = 1; k <= 36; k++) begin
            @(negedge cclk);
            if (config_set) cs_cyc.push_back(k);
            chk("b2b_req_ready", 32'(req_ready), 32'(k == 18 || k == 36));
            if (k == 18) begin
                @(posedge cclk);
                #1;
                req_valid = 1'b0;
            end
        end
        chk("b2b_cs_pulses", 32'(cs_cyc.size()), 32'(2));
        if (cs_cyc.size() == 2) begin
            chk("b2b_cs_first", 32'(cs_cyc[0]), 32'(17));
            chk("b2b_cs_spacing", 32'(cs_cyc[1] - cs_cyc[0]), 32'(18));
        end

        // 3: inputs changed mid-shift
        do_write(8'h33, 8'h44, 5);

        // 4: reset at shift cycle 7
        @(negedge cclk);
        req_valid = 1'b1;
        req_addr  = 8'h77;
        req_data  = 8'h88;
        push_word(8'h77, 8'h88);
        rbq.push_back(chain);
        @(posedge cclk);
        #1;
        req_valid = 1'b0;
        repeat (7) @(negedge cclk);
        rst = 1'b1;
        cs_before = cs_count;
        @(posedge cclk);
        #1;
        rst = 1'b0;
        bitq.delete();
        wq.delete();
        rbq.delete();
        @(negedge cclk);
        chk("rst_mid_shift_enable", 32'(shift_enable), 32'(0));
        chk("rst_mid_busy", 32'(busy), 32'(0));
        chk("rst_mid_req_ready", 32'(req_ready), 32'(1));
        chk("rst_mid_config_set", 32'(config_set), 32'(0));
        repeat (20) begin
            @(negedge cclk);
            chk("rst_mid_no_cs", 32'(config_set), 32'(0));
        end
        chk("rst_mid_cs_count", 32'(cs_count), 32'(cs_before));
        do_write(8'h10, 8'h20, 0);

        // 5: idle
        cs_before = cs_count;
        repeat (50) begin
            @(negedge cclk);
            chk("idle_shift_enable", 32'(shift_enable), 32'(0));
            chk("idle_shift_in", 32'(shift_in), 32'(0));
            chk("idle_config_set", 32'(config_set), 32'(0));
            chk("idle_req_ready", 32'(req_ready), 32'(1));
        end
        chk("idle_cs_count", 32'(cs_count), 32'(cs_before));

`ifdef CFG_SER_READBACK_EN
        // 6: readback of a preloaded chain
        @(negedge cclk);
        preload_val = {8'hA5, 8'h3C};
        preload_req = 1'b1;
        @(negedge cclk);
        preload_req = 1'b0;
        do_write(8'h00, 8'h00, 0);
        chk("rb_preloaded", 32'(last_rb), 32'h0000A53C);
`endif

        repeat (3) @(negedge cclk);
        chk("bitq_drained", 32'(bitq.size()), 32'(0));
        chk("wq_drained", 32'(wq.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
